// File: rtl/pw_conv_sequencer.sv
// Pointwise-convolution sequencer: for one spatial position, streams the Cin-deep
// activation/weight chunks into the MAC engine once per output channel and forwards each result.
module pw_conv_sequencer #(
    parameter int NUM_MACS     = 16,
    parameter int AADDR_W      = 5,
    parameter int WADDR_W      = 13,
    parameter int WAIT_TIMEOUT = 64
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [9:0]            cfg_num_in_ch,
    input  logic [9:0]            cfg_num_out_ch,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  cfg_err,
    output logic                  act_rd_en,
    output logic [AADDR_W-1:0]    act_rd_addr,
    input  logic [NUM_MACS*8-1:0] act_rd_data,
    output logic                  wgt_rd_en,
    output logic [WADDR_W-1:0]    wgt_rd_addr,
    input  logic [NUM_MACS*8-1:0] wgt_rd_data,
    output logic                  eng_start_conv,
    output logic                  eng_clear,
    output logic                  eng_load_data,
    output logic [NUM_MACS*8-1:0] eng_activations,
    output logic [NUM_MACS*8-1:0] eng_weights,
    input  logic [31:0]           eng_result,
    input  logic                  eng_result_valid,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [31:0]           res_data,
    output logic [9:0]            res_channel
);
    localparam int TMO_W = $clog2(WAIT_TIMEOUT + 1);

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_FEED, S_WAIT, S_OUT, S_FIN} state_t;

    state_t             state_q;
    logic [9:0]         cin_q, cout_q, nch_q, oc_q, k_q;
    logic [WADDR_W-1:0] wgt_next_q;
    logic [TMO_W-1:0]   wait_cnt_q;
    logic               cfg_err_q, done_q, res_valid_q;
    logic               act_rd_en_q, wgt_rd_en_q, start_conv_q, clear_q, load_q;
    logic [AADDR_W-1:0] act_addr_q;
    logic [WADDR_W-1:0] wgt_addr_q;
    logic [31:0]        res_data_q;
    logic [9:0]         res_channel_q;

    logic               cfg_ok;
    logic [9:0]         nch_d;
    logic [15:0]        chunk_base;

    assign cfg_ok = (cfg_num_in_ch != 10'd0) && (cfg_num_in_ch <= 10'd320) &&
                    (cfg_num_out_ch != 10'd0) && (cfg_num_out_ch <= 10'd320);
    assign nch_d  = 10'((11'(cfg_num_in_ch) + 11'(NUM_MACS - 1)) / 11'(NUM_MACS));

    // Weight rows are consumed strictly in order (oc*NCH+k), so a running pointer
    // replaces the oc*NCH multiply.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= S_IDLE;
            cin_q         <= '0;
            cout_q        <= '0;
            nch_q         <= '0;
            oc_q          <= '0;
            k_q           <= '0;
            wgt_next_q    <= '0;
            wait_cnt_q    <= '0;
            cfg_err_q     <= 1'b0;
            done_q        <= 1'b0;
            res_valid_q   <= 1'b0;
            act_rd_en_q   <= 1'b0;
            wgt_rd_en_q   <= 1'b0;
            start_conv_q  <= 1'b0;
            clear_q       <= 1'b0;
            load_q        <= 1'b0;
            act_addr_q    <= '0;
            wgt_addr_q    <= '0;
            res_data_q    <= '0;
            res_channel_q <= '0;
        end else begin
            clear_q      <= 1'b0;
            start_conv_q <= 1'b0;
            done_q       <= 1'b0;
            act_rd_en_q  <= 1'b0;
            wgt_rd_en_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        cin_q  <= cfg_num_in_ch;
                        cout_q <= cfg_num_out_ch;
                        nch_q  <= nch_d;
                        oc_q   <= '0;
                        if (cfg_ok) begin
                            cfg_err_q    <= 1'b0;
                            state_q      <= S_ISSUE;
                            clear_q      <= 1'b1;
                            start_conv_q <= 1'b1;
                            act_rd_en_q  <= 1'b1;
                            act_addr_q   <= '0;
                            wgt_rd_en_q  <= 1'b1;
                            wgt_addr_q   <= '0;
                            wgt_next_q   <= WADDR_W'(1);
                        end else begin
                            cfg_err_q <= 1'b1;
                            done_q    <= 1'b1;
                            state_q   <= S_FIN;
                        end
                    end
                end
                S_ISSUE: begin
                    state_q <= S_FEED;
                    load_q  <= 1'b1;
                    k_q     <= '0;
                    if (nch_q > 10'd1) begin
                        act_rd_en_q <= 1'b1;
                        act_addr_q  <= AADDR_W'(1);
                        wgt_rd_en_q <= 1'b1;
                        wgt_addr_q  <= wgt_next_q;
                        wgt_next_q  <= wgt_next_q + WADDR_W'(1);
                    end
                end
                S_FEED: begin
                    if (k_q == nch_q - 10'd1) begin
                        load_q     <= 1'b0;
                        wait_cnt_q <= '0;
                        state_q    <= S_WAIT;
                    end else begin
                        k_q <= k_q + 10'd1;
                        // Prefetch one chunk ahead so read data lands in the next FEED cycle.
                        if (k_q + 10'd2 < nch_q) begin
                            act_rd_en_q <= 1'b1;
                            act_addr_q  <= AADDR_W'(k_q + 10'd2);
                            wgt_rd_en_q <= 1'b1;
                            wgt_addr_q  <= wgt_next_q;
                            wgt_next_q  <= wgt_next_q + WADDR_W'(1);
                        end
                    end
                end
                S_WAIT: begin
                    if (eng_result_valid) begin
                        res_data_q    <= eng_result;
                        res_channel_q <= oc_q;
                        res_valid_q   <= 1'b1;
                        state_q       <= S_OUT;
                    end else if (wait_cnt_q == TMO_W'(WAIT_TIMEOUT - 1)) begin
                        cfg_err_q <= 1'b1;
                        done_q    <= 1'b1;
                        state_q   <= S_FIN;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + TMO_W'(1);
                    end
                end
                S_OUT: begin
                    if (res_ready) begin
                        res_valid_q <= 1'b0;
                        if (oc_q == cout_q - 10'd1) begin
                            done_q  <= 1'b1;
                            state_q <= S_FIN;
                        end else begin
                            oc_q         <= oc_q + 10'd1;
                            state_q      <= S_ISSUE;
                            clear_q      <= 1'b1;
                            start_conv_q <= 1'b1;
                            act_rd_en_q  <= 1'b1;
                            act_addr_q   <= '0;
                            wgt_rd_en_q  <= 1'b1;
                            wgt_addr_q   <= wgt_next_q;
                            wgt_next_q   <= wgt_next_q + WADDR_W'(1);
                        end
                    end
                end
                S_FIN: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Read data arrives one cycle after the request, i.e. exactly in its FEED cycle;
    // lanes beyond Cin in the final chunk are forced to zero.
    always_comb begin
        eng_activations = '0;
        eng_weights     = '0;
        chunk_base      = 16'(k_q) * 16'(NUM_MACS);
        if (state_q == S_FEED) begin
            for (int i = 0; i < NUM_MACS; i++) begin
                if (chunk_base + 16'(i) < 16'(cin_q)) begin
                    eng_activations[8*i +: 8] = act_rd_data[8*i +: 8];
                    eng_weights[8*i +: 8]     = wgt_rd_data[8*i +: 8];
                end
            end
        end
    end

    assign busy           = (state_q != S_IDLE);
    assign done           = done_q;
    assign cfg_err        = cfg_err_q;
    assign act_rd_en      = act_rd_en_q;
    assign act_rd_addr    = act_addr_q;
    assign wgt_rd_en      = wgt_rd_en_q;
    assign wgt_rd_addr    = wgt_addr_q;
    assign eng_start_conv = start_conv_q;
    assign eng_clear      = clear_q;
    assign eng_load_data  = load_q;
    assign res_valid      = res_valid_q;
    assign res_data       = res_data_q;
    assign res_channel    = res_channel_q;

endmodule

// File: tb/tb_pw_conv_sequencer.sv
// Testbench for pw_conv_sequencer: buffer and engine models plus a result scoreboard.
module tb_pw_conv_sequencer;
    localparam int NUM_MACS = 16;
    localparam int AADDR_W  = 5;
    localparam int WADDR_W  = 13;
    localparam int LW       = NUM_MACS * 8;

    logic               clock, reset, start, busy, done, cfg_err;
    logic [9:0]         cfg_num_in_ch, cfg_num_out_ch;
    logic               act_rd_en, wgt_rd_en;
    logic [AADDR_W-1:0] act_rd_addr;
    logic [WADDR_W-1:0] wgt_rd_addr;
    logic [LW-1:0]      act_rd_data, wgt_rd_data, eng_activations, eng_weights;
    logic               eng_start_conv, eng_clear, eng_load_data;
    logic [31:0]        eng_result;
    logic               eng_result_valid;
    logic               res_valid, res_ready;
    logic [31:0]        res_data;
    logic [9:0]         res_channel;

    pw_conv_sequencer #(.NUM_MACS(NUM_MACS), .AADDR_W(AADDR_W), .WADDR_W(WADDR_W), .WAIT_TIMEOUT(64)) dut (
        .clock(clock), .reset(reset),
        .cfg_num_in_ch(cfg_num_in_ch), .cfg_num_out_ch(cfg_num_out_ch),
        .start(start), .busy(busy), .done(done), .cfg_err(cfg_err),
        .act_rd_en(act_rd_en), .act_rd_addr(act_rd_addr), .act_rd_data(act_rd_data),
        .wgt_rd_en(wgt_rd_en), .wgt_rd_addr(wgt_rd_addr), .wgt_rd_data(wgt_rd_data),
        .eng_start_conv(eng_start_conv), .eng_clear(eng_clear), .eng_load_data(eng_load_data),
        .eng_activations(eng_activations), .eng_weights(eng_weights),
        .eng_result(eng_result), .eng_result_valid(eng_result_valid),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_channel(res_channel)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    logic [LW-1:0] act_mem [0:31];
    logic [LW-1:0] wgt_mem [0:63];

    always @(posedge clock) begin
        if (act_rd_en) act_rd_data <= act_mem[act_rd_addr];
        if (wgt_rd_en) wgt_rd_data <= (wgt_rd_addr < 64) ? wgt_mem[wgt_rd_addr[5:0]] : '0;
    end

    // Engine model: signed int8 dot-product accumulator, result 3 cycles after the last load.
    bit eng_respond;
    int acc, lat_cnt;
    logic prev_load;

    function automatic int dot(input logic [LW-1:0] a, input logic [LW-1:0] w);
        int s = 0;
        for (int i = 0; i < NUM_MACS; i++)
            s += int'($signed(a[8*i +: 8])) * int'($signed(w[8*i +: 8]));
        return s;
    endfunction

    always @(posedge clock) begin
        if (reset) begin
            acc <= 0; lat_cnt <= 0; prev_load <= 1'b0; eng_result_valid <= 1'b0; eng_result <= '0;
        end else begin
            eng_result_valid <= 1'b0;
            prev_load <= eng_load_data;
            if (eng_clear) acc <= 0;
            else if (eng_load_data) acc <= acc + dot(eng_activations, eng_weights);
            if (prev_load && !eng_load_data && eng_respond) lat_cnt <= 3;
            else if (lat_cnt != 0) begin
                lat_cnt <= lat_cnt - 1;
                if (lat_cnt == 1) begin eng_result_valid <= 1'b1; eng_result <= 32'(acc); end
            end
        end
    end

    typedef struct { logic [31:0] data; logic [9:0] ch; } exp_t;
    exp_t sb[$];
    int checks = 0, failures = 0;
    int cyc = 0, issue_cnt, load_cnt, rd_cnt, strobe_cnt, done_cnt, hs_cnt, mask_err;
    int last_load_cyc, done_cyc, hs_cyc, feed_idx, cur_cin;
    int act_addrs[$], wgt_addrs[$];

    // Monitor / scoreboard, sampled on the falling edge.
    always @(negedge clock) begin
        exp_t e;
        cyc++;
        if (!reset) begin
            if (eng_start_conv) begin issue_cnt++; feed_idx = 0; end
            if (eng_load_data) begin
                load_cnt++; last_load_cyc = cyc;
                for (int i = 0; i < NUM_MACS; i++)
                    if (feed_idx * NUM_MACS + i >= cur_cin &&
                        (eng_activations[8*i +: 8] != 8'd0 || eng_weights[8*i +: 8] != 8'd0)) mask_err++;
                feed_idx++;
            end else if (eng_activations != '0 || eng_weights != '0) mask_err++;
            if (act_rd_en || wgt_rd_en) rd_cnt++;
            if (act_rd_en) act_addrs.push_back(int'(act_rd_addr));
            if (wgt_rd_en) wgt_addrs.push_back(int'(wgt_rd_addr));
            if (eng_start_conv || eng_clear || eng_load_data) strobe_cnt++;
            if (done) begin done_cnt++; done_cyc = cyc; end
            if (res_valid && res_ready) begin
                hs_cnt++; hs_cyc = cyc;
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL sb_unexpected got ch=%0d data=%0d required no result", res_channel, res_data);
                end else begin
                    e = sb.pop_front();
                    if (res_data !== e.data || res_channel !== e.ch) begin
                        failures++;
                        $display("FAIL sb_result got ch=%0d data=%0d required ch=%0d data=%0d",
                                 res_channel, $signed(res_data), e.ch, $signed(e.data));
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock); #1;
    endtask

    task automatic clear_stats();
        issue_cnt = 0; load_cnt = 0; rd_cnt = 0; strobe_cnt = 0; done_cnt = 0; hs_cnt = 0;
        mask_err = 0; act_addrs.delete(); wgt_addrs.delete();
    endtask

    function automatic logic [31:0] model(input int cin, input int oc);
        int nch = (cin + NUM_MACS - 1) / NUM_MACS;
        int s = 0;
        logic [LW-1:0] ar, wr;
        for (int c = 0; c < cin; c++) begin
            ar = act_mem[c / NUM_MACS];
            wr = wgt_mem[oc * nch + c / NUM_MACS];
            s += int'($signed(ar[8*(c%NUM_MACS) +: 8])) * int'($signed(wr[8*(c%NUM_MACS) +: 8]));
        end
        return 32'(s);
    endfunction

    task automatic fill_const(input logic [7:0] a, input logic [7:0] w);
        for (int i = 0; i < 32; i++) act_mem[i] = {NUM_MACS{a}};
        for (int i = 0; i < 64; i++) wgt_mem[i] = {NUM_MACS{w}};
    endtask

    task automatic fill_rand();
        for (int i = 0; i < 32; i++)
            for (int l = 0; l < NUM_MACS; l++) act_mem[i][8*l +: 8] = 8'($urandom_range(1, 255));
        for (int i = 0; i < 64; i++)
            for (int l = 0; l < NUM_MACS; l++) wgt_mem[i][8*l +: 8] = 8'($urandom_range(1, 255));
    endtask

    // Pulses start for one edge, then scrambles cfg to prove it was latched.
    task automatic do_start(input int cin, input int cout, input bit push);
        exp_t e;
        if (push)
            for (int oc = 0; oc < cout; oc++) begin
                e.data = model(cin, oc); e.ch = 10'(oc); sb.push_back(e);
            end
        cur_cin = cin;
        cfg_num_in_ch = 10'(cin); cfg_num_out_ch = 10'(cout); start = 1'b1;
        tick();
        start = 1'b0; cfg_num_in_ch = 10'd7; cfg_num_out_ch = 10'd9;
    endtask

    task automatic wait_done(input int budget, input string name);
        int d0 = done_cnt;
        int n = 0;
        while (done_cnt == d0 && n < budget) begin tick(); n++; end
        tick();
        checks++;
        if (done_cnt == d0) begin
            failures++;
            $display("FAIL %s_done got done_seen=0 required 1 within %0d cycles", name, budget);
        end
    endtask

    task automatic check_sb_empty(input string name);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL %s_pending got %0d outstanding results required 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        checks++;
        if ({busy, done, cfg_err} !== 3'b000) begin
            failures++; $display("FAIL reset_ctrl got busy/done/err=%b required 000", {busy, done, cfg_err});
        end
        checks++;
        if ({res_valid, res_data, res_channel} !== '0) begin
            failures++; $display("FAIL reset_res got v=%b d=%h ch=%h required 0", res_valid, res_data, res_channel);
        end
        checks++;
        if ({act_rd_en, act_rd_addr, wgt_rd_en, wgt_rd_addr} !== '0) begin
            failures++; $display("FAIL reset_rd got %b/%h/%b/%h required 0", act_rd_en, act_rd_addr, wgt_rd_en, wgt_rd_addr);
        end
        checks++;
        if ({eng_start_conv, eng_clear, eng_load_data, eng_activations, eng_weights} !== '0) begin
            failures++; $display("FAIL reset_eng got strobes=%b required 000", {eng_start_conv, eng_clear, eng_load_data});
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        fill_const(8'd1, 8'd2);
        clear_stats();
        do_start(16, 1, 1'b1);
        wait_done(200, "basic");
        checks++;
        if (load_cnt != 1) begin failures++; $display("FAIL basic_loads got %0d required 1", load_cnt); end
        checks++;
        if (hs_cnt != 1 || done_cyc - hs_cyc != 1) begin
            failures++; $display("FAIL basic_done_lat got hs=%0d gap=%0d required 1/1", hs_cnt, done_cyc - hs_cyc);
        end
        checks++;
        if (done_cnt != 1 || cfg_err !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("FAIL basic_end got done=%0d err=%b busy=%b required 1/0/0", done_cnt, cfg_err, busy);
        end
        check_sb_empty("basic");
    endtask

    task automatic test_partial_chunk();
        fill_rand();
        clear_stats();
        do_start(20, 2, 1'b1);
        wait_done(300, "partial");
        checks++;
        if (load_cnt != 4) begin failures++; $display("FAIL partial_loads got %0d required 4", load_cnt); end
        checks++;
        if (mask_err != 0) begin failures++; $display("FAIL partial_mask got %0d bad lanes required 0", mask_err); end
        checks++;
        if (wgt_addrs != '{0, 1, 2, 3}) begin
            failures++; $display("FAIL partial_waddr got %p required 0,1,2,3", wgt_addrs);
        end
        checks++;
        if (act_addrs != '{0, 1, 0, 1}) begin
            failures++; $display("FAIL partial_aaddr got %p required 0,1,0,1", act_addrs);
        end
        check_sb_empty("partial");
    endtask

    task automatic test_backpressure();
        int n;
        logic [31:0] held;
        fill_rand();
        clear_stats();
        res_ready = 1'b1;
        do_start(16, 3, 1'b1);
        n = 0;
        while (hs_cnt < 1 && n < 200) begin tick(); n++; end
        res_ready = 1'b0;
        n = 0;
        while (!res_valid && n < 200) begin tick(); n++; end
        checks++;
        if (!res_valid || res_channel !== 10'd1) begin
            failures++; $display("FAIL bp_arrive got v=%b ch=%0d required 1/1", res_valid, res_channel);
        end
        held = res_data;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (res_valid !== 1'b1 || res_data !== held || res_channel !== 10'd1 || issue_cnt != 2) begin
                failures++;
                $display("FAIL bp_hold got v=%b d=%h ch=%0d issues=%0d required 1/%h/1/2",
                         res_valid, res_data, res_channel, issue_cnt, held);
            end
        end
        res_ready = 1'b1;
        wait_done(300, "bp");
        checks++;
        if (issue_cnt != 3 || hs_cnt != 3) begin
            failures++; $display("FAIL bp_count got issues=%0d results=%0d required 3/3", issue_cnt, hs_cnt);
        end
        check_sb_empty("bp");
    endtask

    task automatic test_cfg_err();
        int cins[2] = '{0, 16};
        int couts[2] = '{1, 321};
        for (int t = 0; t < 2; t++) begin
            clear_stats();
            do_start(cins[t], couts[t], 1'b0);
            wait_done(20, "cfgerr");
            checks++;
            if (cfg_err !== 1'b1 || done_cnt != 1 || rd_cnt != 0 || strobe_cnt != 0) begin
                failures++;
                $display("FAIL cfgerr_%0d got err=%b done=%0d rd=%0d strobes=%0d required 1/1/0/0",
                         t, cfg_err, done_cnt, rd_cnt, strobe_cnt);
            end
        end
        fill_rand();
        clear_stats();
        do_start(16, 1, 1'b1);
        checks++;
        if (cfg_err !== 1'b0) begin failures++; $display("FAIL cfgerr_clear got %b required 0", cfg_err); end
        wait_done(200, "cfgerr_recover");
        check_sb_empty("cfgerr");
    endtask

    task automatic test_timeout();
        int n;
        fill_rand();
        clear_stats();
        eng_respond = 1'b0;
        do_start(48, 2, 1'b0);
        n = 0;
        while (!eng_load_data && n < 20) begin tick(); n++; end
        cfg_num_in_ch = 10'd16; cfg_num_out_ch = 10'd1; start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(300, "timeout");
        checks++;
        if (cfg_err !== 1'b1 || done_cnt != 1 || issue_cnt != 1 || hs_cnt != 0) begin
            failures++;
            $display("FAIL timeout_state got err=%b done=%0d issues=%0d results=%0d required 1/1/1/0",
                     cfg_err, done_cnt, issue_cnt, hs_cnt);
        end
        checks++;
        if (load_cnt != 3 || done_cyc - last_load_cyc != 65) begin
            failures++;
            $display("FAIL timeout_len got loads=%0d gap=%0d required 3/65", load_cnt, done_cyc - last_load_cyc);
        end
        eng_respond = 1'b1;
        repeat (3) tick();
    endtask

    task automatic test_reset_mid();
        int n;
        fill_rand();
        clear_stats();
        do_start(32, 2, 1'b1);
        n = 0;
        while (!(issue_cnt == 2 && eng_load_data) && n < 200) begin tick(); n++; end
        checks++;
        if (issue_cnt != 2 || !eng_load_data) begin
            failures++; $display("FAIL rstmid_reach got issues=%0d load=%b required 2/1", issue_cnt, eng_load_data);
        end
        reset = 1'b1;
        tick();
        checks++;
        if ({busy, done, cfg_err, act_rd_en, act_rd_addr, wgt_rd_en, wgt_rd_addr, eng_start_conv, eng_clear,
             eng_load_data, eng_activations, eng_weights, res_valid, res_data, res_channel} !== '0) begin
            failures++;
            $display("FAIL rstmid_outputs got busy=%b rd=%b%b load=%b v=%b d=%h ch=%h required all 0",
                     busy, act_rd_en, wgt_rd_en, eng_load_data, res_valid, res_data, res_channel);
        end
        reset = 1'b0;
        sb.delete();
        clear_stats();
        repeat (5) tick();
        checks++;
        if (rd_cnt != 0 || strobe_cnt != 0 || done_cnt != 0 || hs_cnt != 0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_quiet got rd=%0d strobes=%0d done=%0d res=%0d busy=%b required 0",
                     rd_cnt, strobe_cnt, done_cnt, hs_cnt, busy);
        end
        do_start(16, 1, 1'b1);
        wait_done(200, "rstmid_fresh");
        check_sb_empty("rstmid");
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; res_ready = 1'b1; eng_respond = 1'b1;
        cfg_num_in_ch = '0; cfg_num_out_ch = '0; cur_cin = 0;
        clear_stats();
        test_reset();
        test_basic();
        test_partial_chunk();
        test_backpressure();
        test_cfg_err();
        test_timeout();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pw_conv_sequencer.md
PW_CONV_SEQUENCER -- requirements
Module: pw_conv_sequencer

Interface
REQ-001 SHALL have parameter NUM_MACS, default 16: lanes per chunk, equal to the engine MAC count.
REQ-002 SHALL have parameter AADDR_W, default 5: activation buffer address width, in chunks.
REQ-003 SHALL have parameter WADDR_W, default 13: weight buffer address width, in chunks.
REQ-004 SHALL have parameter WAIT_TIMEOUT, default 64: maximum cycles spent in WAIT.
REQ-005 clock  in  1  clock; all logic is on the rising edge.
REQ-006 reset  in  1  reset, synchronous, active-high.
REQ-007 Configuration and control ports:
- cfg_num_in_ch  in  10  input channel count (Cin).
- cfg_num_out_ch  in  10  output channel count (Cout).
- start  in  1  begin one spatial position.
- busy  out  1  high whenever the FSM is not IDLE.
- done  out  1  one-cycle completion pulse.
- cfg_err  out  1  sticky error flag; cleared by the next accepted start.
REQ-008 Activation buffer read port:
- act_rd_en  out  1  read request.
- act_rd_addr  out  AADDR_W  chunk index k.
- act_rd_data  in  NUM_MACS*8  read data, 1-cycle read latency; lane i at bits [8i+7:8i].
REQ-009 Weight buffer read port:
- wgt_rd_en  out  1  read request.
- wgt_rd_addr  out  WADDR_W  oc*NCH+k.
- wgt_rd_data  in  NUM_MACS*8  read data, 1-cycle read latency.
REQ-010 Engine-side ports:
- eng_start_conv  out  1  start pulse to the engine.
- eng_clear  out  1  accumulator clear to the engine.
- eng_load_data  out  1  chunk-valid strobe.
- eng_activations  out  NUM_MACS*8  activation lanes.
- eng_weights  out  NUM_MACS*8  weight lanes.
- eng_result  in  32  engine result.
- eng_result_valid  in  1  one-cycle result pulse.
REQ-011 Result stream ports:
- res_valid  out  1  result available.
- res_ready  in  1  downstream accept.
- res_data  out  32  captured result.
- res_channel  out  10  output channel index of res_data.

Function
REQ-012 SHALL latch Cin and Cout when start is accepted, with NCH = ceil(Cin/NUM_MACS); all later cfg_* changes are ignored until the next accepted start.
REQ-013 SHALL use FSM states IDLE, ISSUE, FEED, WAIT, OUT, FIN; start is accepted only in IDLE and ignored in every other state.
REQ-014 IDLE + start with a valid config (1<=Cin<=320 and 1<=Cout<=320): SHALL set oc=0 and go to ISSUE.
REQ-015 IDLE + start with an invalid config: SHALL set cfg_err=1 and go to FIN, issuing no reads and no engine strobes.
REQ-016 ISSUE (one cycle) SHALL assert:
- eng_clear=1 and eng_start_conv=1.
- act_rd_en=1 with addr 0.
- wgt_rd_en=1 with addr oc*NCH.
Then go to FEED.
REQ-017 FEED SHALL last exactly NCH cycles. In FEED cycle j (j=0..NCH-1):
- eng_load_data=1.
- eng_activations and eng_weights = the read data returned for chunk j.
- For j<NCH-1, reads for chunk j+1 are issued in the same cycle.
After cycle NCH-1, go to WAIT.
REQ-018 Lane masking: lane i of chunk j SHALL be driven 0 on both activations and weights when j*NUM_MACS+i >= Cin; all other lanes pass read data unmodified.
REQ-019 Outside FEED, eng_load_data SHALL be 0 and eng_activations/eng_weights SHALL be 0.
REQ-020 WAIT on eng_result_valid: SHALL capture eng_result into res_data, set res_channel=oc, and go to OUT.
REQ-021 WAIT timeout: after WAIT_TIMEOUT cycles without eng_result_valid, SHALL set cfg_err=1 and go to FIN.
REQ-022 OUT SHALL hold res_valid=1 with stable res_data/res_channel until res_ready=1. On the handshake cycle:
- If oc==Cout-1, go to FIN.
- Otherwise oc++ and go to ISSUE.
REQ-023 res_valid SHALL be 0 in every state except OUT.
REQ-024 FIN SHALL assert done=1 for one cycle, then go to IDLE.
REQ-025 eng_result_valid outside WAIT SHALL be ignored.
REQ-026 Address arithmetic SHALL be unsigned with no wrap for legal configs; oc*NCH+k <= 6399.

Reset
REQ-027 On reset SHALL go to IDLE, oc=0, cfg_err=0, and every output 0, including res_data and res_channel.
REQ-028 Reset asserted mid-operation SHALL abort within the same edge: no further reads, strobes or res_valid, and no done pulse.

Verification
REQ-029 Cin=16, Cout=1, all acts=1, all weights=2, engine model returns the dot product -> 1 load_data cycle; res_data=32, res_channel=0; done 1 cycle after handshake.
REQ-030 Cin=20, Cout=2, NUM_MACS=16 -> 2 FEED cycles per channel; lanes 4..15 of chunk 1 zero; wgt_rd_addr sequence 0,1,2,3; two results on channels 0 and 1.
REQ-031 Cin=16, Cout=3, res_ready low for 5 cycles on channel 1 -> res_valid and res_data held stable; no ISSUE until the handshake; three results in order 0,1,2.
REQ-032 Cin=0 or Cout=321 -> cfg_err=1, done pulse, zero rd_en and engine strobes; a following valid start clears cfg_err.
REQ-033 Engine model never returns valid -> after 64 WAIT cycles cfg_err=1 and done pulses; start asserted during FEED is ignored.
REQ-034 Reset asserted in FEED of channel 1 -> next cycle all outputs 0 and FSM in IDLE; a fresh start runs to completion.
